// File: rtl/display_pkg.sv
// Shared display constants: active-low 7-segment glyphs (bit order g..a)
// and the BCD-to-segment decode used by the HEX display path.
package display_pkg;

  localparam int BCD_MAX_DIGIT = 9;

  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_0000;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  // Non-decimal codes never reach here from the counter; show blank anyway.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell. cin means "every lower digit is at its rollover edge",
// so the cell moves on step only when cin is set; cout extends that chain.
module bcd_digit
  import display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_d,
  input  logic       step,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);

  logic [3:0] r_q;
  logic       w_edge;

  assign w_edge = up ? (r_q == 4'(BCD_MAX_DIGIT)) : (r_q == 4'd0);
  assign cout   = cin && w_edge;
  assign q      = r_q;

  // Digit register: reset, load, or roll by one in the current direction.
  always_ff @(posedge clk) begin
    if (rst)
      r_q <= 4'd0;
    else if (load)
      r_q <= load_d;
    else if (step && cin) begin
      if (up)
        r_q <= w_edge ? 4'd0 : r_q + 4'd1;
      else
        r_q <= w_edge ? 4'(BCD_MAX_DIGIT) : r_q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_event_counter.sv
// Multi-digit BCD event counter with prescaler, up/down, load with digit
// clamp, wrap/saturate, and active-low 7-segment outputs with LZ blanking.
module bcd_event_counter
  import display_pkg::*;
#(
  parameter int DIGITS   = 5,
  parameter int PRESCALE = 50_000_000,
  parameter int SATURATE = 0,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  wrap,
  output logic                  at_limit
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]       r_pre;
  logic                r_wrap;
  logic                w_tick;
  logic                w_step;
  logic [DIGITS:0]     w_carry;
  logic [4*DIGITS-1:0] w_load_d;
  logic                w_hi_zero;

  // With PRESCALE=1 the compare value is 0 and r_pre never leaves 0, so tick = en.
  assign w_tick = en && (r_pre == PW'(PRESCALE - 1));

  // The carry chain seeded with 1 reports "every digit at its edge", which
  // is exactly the limit in the current direction.
  assign w_carry[0] = 1'b1;
  assign at_limit   = w_carry[DIGITS];

  // Saturation: suppress the digit update at the limit; wrap still pulses.
  assign w_step = w_tick && !((SATURATE != 0) && at_limit);
  assign wrap   = r_wrap;

  // Prescaler: free-runs while enabled, pauses on !en, cleared by rst/load.
  always_ff @(posedge clk) begin
    if (rst || load)
      r_pre <= '0;
    else if (en)
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
  end

  // Wrap flag: one cycle after any tick that found the count at its limit.
  always_ff @(posedge clk) begin
    if (rst || load)
      r_wrap <= 1'b0;
    else
      r_wrap <= w_tick && at_limit;
  end

  // Load clamp: any non-decimal nibble is forced to 9.
  always_comb begin
    w_load_d = '0;
    for (int i = 0; i < DIGITS; i++)
      w_load_d[4*i +: 4] = (load_val[4*i +: 4] > 4'(BCD_MAX_DIGIT))
                           ? 4'(BCD_MAX_DIGIT) : load_val[4*i +: 4];
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .load_d (w_load_d[4*g +: 4]),
      .step   (w_step),
      .up     (up),
      .cin    (w_carry[g]),
      .q      (count_bcd[4*g +: 4]),
      .cout   (w_carry[g+1])
    );
  end

  // Segment decode, scanning from the top digit so w_hi_zero tracks
  // "this digit and all above are zero"; digit 0 is never blanked.
  always_comb begin
    w_hi_zero = 1'b1;
    seg       = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_hi_zero = w_hi_zero && (count_bcd[4*i +: 4] == 4'd0);
      if ((BLANK_LZ != 0) && (i > 0) && w_hi_zero)
        seg[7*i +: 7] = SEG_BLANK;
      else
        seg[7*i +: 7] = bcd_to_seg(count_bcd[4*i +: 4]);
    end
  end

endmodule

// File: tb/tb_bcd_event_counter.sv
// Three 3-digit counters (wrap, saturate, prescale-by-4) share one input
// stream and are each checked every cycle against an integer-valued model.
module tb_bcd_event_counter;

  localparam int D = 3;
  localparam int MAXV = 999;
  localparam int MP [3] = '{1, 1, 4};
  localparam int MS [3] = '{0, 1, 0};
  localparam logic [6:0] GLY [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [4*D-1:0] load_val = '0;
  logic [2:0][4*D-1:0] cnt;
  logic [2:0][7*D-1:0] seg;
  logic [2:0] wrap, lim;

  int m_cnt [3];
  int m_pre [3];
  bit m_wrap [3];
  int n_chk = 0;
  int n_err = 0;

  bcd_event_counter #(.DIGITS(D), .PRESCALE(1), .SATURATE(0), .BLANK_LZ(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count_bcd(cnt[0]), .seg(seg[0]), .wrap(wrap[0]), .at_limit(lim[0]));
  bcd_event_counter #(.DIGITS(D), .PRESCALE(1), .SATURATE(1), .BLANK_LZ(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count_bcd(cnt[1]), .seg(seg[1]), .wrap(wrap[1]), .at_limit(lim[1]));
  bcd_event_counter #(.DIGITS(D), .PRESCALE(4), .SATURATE(0), .BLANK_LZ(1)) u2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count_bcd(cnt[2]), .seg(seg[2]), .wrap(wrap[2]), .at_limit(lim[2]));

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r = '0;
    int p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7*D-1:0] seg_of(input int v);
    logic [7*D-1:0] r = '0;
    int p = 1;
    for (int i = 0; i < D; i++) begin
      r[7*i +: 7] = (i > 0 && v < p) ? 7'h7F : GLY[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [4*D-1:0] lv);
    int r = 0;
    int p = 1;
    for (int i = 0; i < D; i++) begin
      r = r + ((lv[4*i +: 4] > 4'd9) ? 9 : int'(lv[4*i +: 4])) * p;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance the model on the edge, compare #1 later.
  task automatic cyc(input bit r, input bit l, input bit e, input bit u,
                     input logic [4*D-1:0] lv);
    bit tick;
    rst = r; load = l; en = e; up = u; load_val = lv;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        m_cnt[k] = 0; m_pre[k] = 0; m_wrap[k] = 0;
      end else if (l) begin
        m_cnt[k] = clamp_val(lv); m_pre[k] = 0; m_wrap[k] = 0;
      end else begin
        tick = e && (m_pre[k] == MP[k] - 1);
        if (e) m_pre[k] = tick ? 0 : m_pre[k] + 1;
        m_wrap[k] = 0;
        if (tick) begin
          if (u) begin
            if (m_cnt[k] == MAXV) begin
              m_wrap[k] = 1;
              if (MS[k] == 0) m_cnt[k] = 0;
            end else m_cnt[k] = m_cnt[k] + 1;
          end else begin
            if (m_cnt[k] == 0) begin
              m_wrap[k] = 1;
              if (MS[k] == 0) m_cnt[k] = MAXV;
            end else m_cnt[k] = m_cnt[k] - 1;
          end
        end
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_count", k), 32'(cnt[k]), 32'(to_bcd(m_cnt[k])));
      chk($sformatf("u%0d_seg", k), 32'(seg[k]), 32'(seg_of(m_cnt[k])));
      chk($sformatf("u%0d_wrap", k), 32'(wrap[k]), 32'(m_wrap[k]));
      chk($sformatf("u%0d_limit", k), 32'(lim[k]),
          32'(u ? (m_cnt[k] == MAXV) : (m_cnt[k] == 0)));
    end
  endtask

  initial begin
    // Reset: digit 0 shows "0", upper digits blank.
    cyc(1, 0, 0, 1, '0);
    cyc(1, 0, 0, 1, '0);
    chk("rst_count", 32'(cnt[0]), 32'h000);
    chk("rst_seg", 32'(seg[0]), 32'({7'h7F, 7'h7F, 7'h40}));
    chk("rst_wrap", 32'(wrap[0]), 32'h0);

    // Count 000 -> 012.
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 1, '0);
    chk("up12_count", 32'(cnt[0]), 32'h012);
    chk("up12_seg", 32'(seg[0]), 32'({7'h7F, 7'h79, 7'h24}));

    // Up through the top: wrap vs saturate.
    cyc(0, 1, 0, 1, 12'h998);
    cyc(0, 0, 1, 1, '0);
    chk("up_999", 32'(cnt[0]), 32'h999);
    cyc(0, 0, 1, 1, '0);
    chk("up_wrap_cnt", 32'(cnt[0]), 32'h000);
    chk("up_wrap_pulse", 32'(wrap[0]), 32'h1);
    chk("up_sat_cnt", 32'(cnt[1]), 32'h999);
    cyc(0, 0, 1, 1, '0);
    chk("up_after_wrap", 32'(cnt[0]), 32'h001);
    chk("up_wrap_drop", 32'(wrap[0]), 32'h0);
    chk("up_sat_pulse", 32'(wrap[1]), 32'h1);
    chk("up_sat_limit", 32'(lim[1]), 32'h1);

    // Down through zero.
    cyc(0, 1, 0, 0, 12'h001);
    cyc(0, 0, 1, 0, '0);
    chk("dn_000", 32'(cnt[0]), 32'h000);
    cyc(0, 0, 1, 0, '0);
    chk("dn_wrap_cnt", 32'(cnt[0]), 32'h999);
    chk("dn_sat_cnt", 32'(cnt[1]), 32'h000);
    cyc(0, 0, 1, 0, '0);
    chk("dn_after_wrap", 32'(cnt[0]), 32'h998);

    // Prescale 4: 6 on, 5 off, 2 on -> two steps.
    cyc(1, 0, 0, 1, '0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, '0);
    chk("pre_step1", 32'(cnt[2]), 32'h001);
    for (int i = 0; i < 2; i++) cyc(0, 0, 1, 1, '0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, '0);
    cyc(0, 0, 1, 1, '0);
    chk("pre_hold", 32'(cnt[2]), 32'h001);
    cyc(0, 0, 1, 1, '0);
    chk("pre_step2", 32'(cnt[2]), 32'h002);

    // Load beats tick; non-decimal digits clamp to 9.
    cyc(0, 1, 1, 1, 12'hFA5);
    chk("load_clamp", 32'(cnt[0]), 32'h995);

    // Reset beats load and tick.
    cyc(0, 1, 0, 1, 12'h456);
    cyc(1, 1, 1, 1, 12'h456);
    chk("rst_prio_cnt", 32'(cnt[0]), 32'h000);
    chk("rst_prio_seg", 32'(seg[0]), 32'({7'h7F, 7'h7F, 7'h40}));

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(99) == 0), ($urandom_range(19) == 0),
          ($urandom_range(9) < 8), ($urandom_range(7) < 5),
          12'($urandom));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_event_counter.md
# bcd_event_counter

Parametrised multi-digit decimal event counter for the DE-board display path. It counts directly in BCD, so no binary-to-BCD conversion stage is needed. It includes:

- an internal tick prescaler;
- up/down direction;
- synchronous load;
- wrap or saturate at the limits;
- active-low 7-segment outputs with optional leading-zero blanking.

It sits between the board clock and the HEX displays. It replaces the separate divider, binary counter and BCD decoder chain.

## Interface

Parameters:
- DIGITS, 5: number of decimal digits (1–8); the count range is 0 .. 10^DIGITS−1.
- PRESCALE, 50_000_000: clock cycles per count step; 1 means step every enabled cycle.
- SATURATE, 0: 0 wraps at the limits; 1 holds at the limits.
- BLANK_LZ, 1: 1 blanks leading-zero digits; digit 0 is never blanked.

Ports:
- clk  in  1  single clock; all state is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; gates the prescaler and stepping.
- up  in  1  direction: 1 counts up, 0 counts down.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD load value; digit i is at bits [4i+3:4i].
- count_bcd  out  4*DIGITS  registered BCD count.
- seg  out  7*DIGITS  7-segment patterns, active low, bit order g..a; digit i is at bits [7i+6:7i].
- wrap  out  1  one-cycle pulse when the count wraps or hits a limit.
- at_limit  out  1  combinational flag for the limit in the current direction.

## Operation

- Priority, evaluated each rising edge: rst > load > step > hold.
- rst:
  - count_bcd = 0, prescaler = 0, wrap = 0.
  - seg shows "0" on digit 0; the other digits are blank (all 1s) if BLANK_LZ=1, otherwise "0".
- load:
  - count_bcd takes load_val. Any digit greater than 9 is clamped to 9.
  - The prescaler clears to 0 and wrap = 0.
  - load is honoured whether en is high or low.
- Prescaler:
  - Counts 0..PRESCALE−1 while en=1 and holds while en=0.
  - The tick is asserted in the cycle where prescaler == PRESCALE−1 and en=1; the prescaler then returns to 0.
  - With PRESCALE=1, tick = en.
- Step, on tick, up=1:
  - Digit 0 increments; a digit at 9 goes to 0 and carries into the next digit.
  - At all-9s: if SATURATE=0, the count goes to 0 and wrap pulses; if SATURATE=1, the count holds and wrap pulses.
- Step, on tick, up=0:
  - Mirror of the up case: a digit at 0 goes to 9 and borrows from the next digit.
  - At 0: if SATURATE=0, the count goes to all-9s and wrap pulses; if SATURATE=1, the count holds and wrap pulses.
- Holding at a limit under saturation pulses wrap on every tick while the condition persists.
- Changing up between ticks is legal and takes effect on the next tick.
- at_limit = (up && count == all-9s) || (!up && count == 0).
- seg decode:
  - Combinational from count_bcd, standard active-low 0–9 glyphs.
  - A digit is blanked when BLANK_LZ=1, its index is above 0, and it and every higher digit are 0.

## Timing

- count_bcd changes on the edge that samples the tick, or on load or rst: one cycle latency from the strobe.
- wrap is registered. It is high for exactly the cycle after the wrapping edge, coincident with the new count value.
- seg and at_limit follow count_bcd in the same cycle (zero-cycle combinational).
- Minimum step interval is PRESCALE cycles of continuous en.
- Deasserting en mid-interval pauses the prescaler without losing phase.
- rst asserted mid-interval discards the partial prescaler count.

## Structure

- Shared package `display_pkg`:
  - the 7-segment glyph constants SEG_0..SEG_9 and SEG_BLANK;
  - the function `bcd_to_seg`;
  - the constant BCD_MAX_DIGIT = 9.
- Sub-module `bcd_digit`: one decade cell with inputs clk, rst, load, load_d, step, up, cin, and outputs q and cout. DIGITS instances are chained by carry/borrow.
- The top-level block holds the prescaler, the saturation and wrap logic, the load clamp, and the seg/blanking generation.

## Test plan

All scenarios use DIGITS=3, PRESCALE=1 unless noted.

- Reset then en=1, up=1 for 12 cycles → count_bcd steps 000→012; seg digit 2 blank, digit 1 "1", digit 0 "2".
- load 998, up=1, en=1 for 3 cycles → count 999, then 000 with wrap high for one cycle, then 001. With SATURATE=1: holds at 999, wrap pulses each tick, at_limit=1.
- load 001, up=0, 3 ticks → 000, then 999 with a wrap pulse, then 998. Repeat with SATURATE=1: holds at 000.
- PRESCALE=4, en=1 for 6 cycles, en=0 for 5 cycles, en=1 for 2 cycles → exactly one step after cycle 4, a second step on the 8th enabled cycle.
- load_val = 0xFA5, with load and tick in the same cycle → count_bcd = 995; load wins and no step is applied that cycle.
- rst asserted together with load and a tick at count 456 → count 000, wrap 0, prescaler 0; seg digit 0 "0", digits 1–2 blank.
